// File: rtl/inst_uncache_bridge_pkg.sv
// rtl/inst_uncache_bridge_pkg.sv - shared CPU package: uncached fetch bridge states and AXI constants
package inst_uncache_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [2:0] ARSIZE_WORD  = 3'b010;
   localparam logic [1:0] ARBURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [7:0] ARLEN_SINGLE = 8'd0;

endpackage

// File: rtl/inst_uncache_bridge_if.sv
// rtl/inst_uncache_bridge_if.sv - AXI read address/data channel bundle for the uncached fetch bridge
interface inst_uncache_bridge_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/inst_uncache_bridge.sv
// rtl/inst_uncache_bridge.sv - single-outstanding uncached instruction fetch to AXI read bridge
// Optional macro INST_UNCACHE_BUS_ERR_EN reports non-OKAY rresp on inst_bus_err.
module inst_uncache_bridge
   import inst_uncache_bridge_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic                   Clk,
   input  logic                   resetn,
   input  logic                   inst_req,
   input  logic [31:0]            inst_addr,
   input  logic                   exp_flush,
   output logic                   inst_addr_ok,
   output logic                   inst_data_ok,
   output logic [31:0]            inst_rdata,
   output logic                   inst_bus_err,
   inst_uncache_bridge_if.master  axi
);

   state_t      state_q, state_d;
   logic        cancel_q, cancel_d;
   logic [29:0] addr_q;
   logic        accept;
   logic        r_beat;
   logic        capture;
   logic        data_ok_q;
   logic [31:0] rdata_q;

   // Gated by resetn so the handshake stays low while reset is held.
   assign accept = resetn & (state_q == IDLE) & inst_req & ~exp_flush;
   assign r_beat = axi.rvalid & axi.rlast;

   assign inst_addr_ok = accept;
   assign inst_data_ok = data_ok_q;
   assign inst_rdata   = rdata_q;

   assign axi.arid    = AXI_ID;
   assign axi.araddr  = {addr_q, 2'b00};
   assign axi.arlen   = ARLEN_SINGLE;
   assign axi.arsize  = ARSIZE_WORD;
   assign axi.arburst = ARBURST_INCR;
   assign axi.arvalid = (state_q == ADDR);
   assign axi.rready  = (state_q == DATA) | (state_q == DRAIN);

   logic unused_ok;
   assign unused_ok = ^{axi.rid, axi.rresp, inst_addr[1:0]};

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (accept) state_d = ADDR;
         end
         ADDR: begin
            if (exp_flush) cancel_d = 1'b1;
            if (axi.arready) begin
               state_d  = (cancel_q | exp_flush) ? DRAIN : DATA;
               cancel_d = 1'b0;
            end
         end
         DATA: begin
            if (r_beat) begin
               state_d = IDLE;
               capture = ~exp_flush;
            end else if (exp_flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (r_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cancel_q  <= 1'b0;
         addr_q    <= '0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cancel_q  <= cancel_d;
         data_ok_q <= capture;
         if (accept)  addr_q  <= inst_addr[31:2];
         if (capture) rdata_q <= axi.rdata;
      end
   end

`ifdef INST_UNCACHE_BUS_ERR_EN
   logic bus_err_q;
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) bus_err_q <= 1'b0;
      else         bus_err_q <= capture & (axi.rresp != RESP_OKAY);
   end
   assign inst_bus_err = bus_err_q;
`else
   assign inst_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_uncache_bridge.sv
// tb/tb_inst_uncache_bridge.sv - self-checking bench for inst_uncache_bridge with transaction-level model
module tb_inst_uncache_bridge;

   logic        Clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = 32'd0;
   logic        exp_flush = 1'b0;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        inst_bus_err;

   inst_uncache_bridge_if axi ();

   inst_uncache_bridge #(.AXI_ID(4'd0)) dut (
      .Clk          (Clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .exp_flush    (exp_flush),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .inst_bus_err (inst_bus_err),
      .axi          (axi)
   );

   always #5 Clk = ~Clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rdata = 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // mode: 0 none, 1 flush first ADDR cycle, 2 flush first DATA cycle, 3 flush in R handshake cycle
   task automatic run_txn(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input int mode, input logic [31:0] dat, input logic [1:0] resp);
      logic [31:0] aligned;
      logic        cancel;
      logic        exp_err;
      aligned = {addr[31:2], 2'b00};
      cancel  = (mode != 0);
`ifdef INST_UNCACHE_BUS_ERR_EN
      exp_err = !cancel && (resp != 2'b00);
`else
      exp_err = 1'b0;
`endif
      inst_req  = 1'b1;
      inst_addr = addr;
      exp_flush = 1'b0;
      #1 check("addr_ok_idle", {31'd0, inst_addr_ok}, 32'd1);
      @(negedge Clk);
      inst_addr = $urandom;
      for (int i = 0; i <= ar_dly; i++) begin
         inst_req    = 1'($urandom_range(0, 1));
         axi.arready = (i == ar_dly);
         exp_flush   = (mode == 1) && (i == 0);
         #1;
         check("arvalid_addr", {31'd0, axi.arvalid}, 32'd1);
         check("araddr_stable", axi.araddr, aligned);
         check("addr_ok_busy", {31'd0, inst_addr_ok}, 32'd0);
         check("data_ok_quiet_a", {31'd0, inst_data_ok}, 32'd0);
         check("rready_addr", {31'd0, axi.rready}, 32'd0);
         if (i == 0) begin
            check("ar_attrs", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
                  {4'd0, 8'd0, 3'b010, 2'b01});
         end
         @(negedge Clk);
      end
      axi.arready = 1'b0;
      for (int j = 0; j <= r_dly; j++) begin
         inst_req   = 1'($urandom_range(0, 1));
         axi.rvalid = (j == r_dly);
         axi.rlast  = (j == r_dly);
         axi.rid    = 4'($urandom);
         axi.rdata  = (j == r_dly) ? dat : $urandom;
         axi.rresp  = (j == r_dly) ? resp : 2'($urandom);
         exp_flush  = ((mode == 2) && (j == 0)) || ((mode == 3) && (j == r_dly));
         #1;
         check("arvalid_data", {31'd0, axi.arvalid}, 32'd0);
         check("rready_data", {31'd0, axi.rready}, 32'd1);
         check("addr_ok_busy_r", {31'd0, inst_addr_ok}, 32'd0);
         check("data_ok_quiet_r", {31'd0, inst_data_ok}, 32'd0);
         @(negedge Clk);
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      exp_flush  = 1'b0;
      inst_req   = 1'b0;
      if (!cancel) model_rdata = dat;
      #1;
      check("data_ok_result", {31'd0, inst_data_ok}, {31'd0, !cancel});
      check("rdata_result", inst_rdata, model_rdata);
      check("bus_err_result", {31'd0, inst_bus_err}, {31'd0, exp_err});
   endtask

   initial begin
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rid     = 4'd0;
      axi.rdata   = 32'd0;
      axi.rresp   = 2'b00;
      inst_req    = 1'b1;
      #2;
      check("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      check("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
      check("rst_rready", {31'd0, axi.rready}, 32'd0);
      check("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      check("rst_bus_err", {31'd0, inst_bus_err}, 32'd0);
      check("rst_rdata", inst_rdata, 32'd0);
      check("rst_araddr", axi.araddr, 32'd0);
      inst_req = 1'b0;
      @(negedge Clk);
      resetn = 1'b1;
      @(negedge Clk);

      run_txn(32'hBFC00004, 0, 0, 0, 32'h3C08BFC0, 2'b00);
      run_txn(32'h8000_1237, 5, 1, 0, 32'hDEAD_BEEF, 2'b00);
      run_txn(32'h8000_2000, 3, 4, 1, 32'h1111_2222, 2'b00);
      run_txn(32'h8000_3004, 0, 0, 3, 32'h3333_4444, 2'b00);
      run_txn(32'h8000_4008, 1, 3, 2, 32'h5555_6666, 2'b00);
      run_txn(32'h8000_500C, 0, 2, 0, 32'h7777_8888, 2'b10);
      run_txn(32'h8000_6010, 0, 0, 1, 32'h9999_AAAA, 2'b11);

      inst_req  = 1'b1;
      exp_flush = 1'b1;
      #1 check("flush_blocks_accept", {31'd0, inst_addr_ok}, 32'd0);
      @(negedge Clk);
      inst_req  = 1'b0;
      exp_flush = 1'b0;

      for (int k = 0; k < 40; k++) begin
         run_txn($urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                 (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0),
                 $urandom, 2'($urandom));
      end

      inst_req  = 1'b1;
      inst_addr = 32'hA000_0040;
      #1 check("rst_txn_accept", {31'd0, inst_addr_ok}, 32'd1);
      @(negedge Clk);
      inst_req    = 1'b0;
      axi.arready = 1'b1;
      @(negedge Clk);
      axi.arready = 1'b0;
      #1 check("rst_txn_in_data", {31'd0, axi.rready}, 32'd1);
      resetn   = 1'b0;
      inst_req = 1'b1;
      #1;
      check("midrst_arvalid", {31'd0, axi.arvalid}, 32'd0);
      check("midrst_rready", {31'd0, axi.rready}, 32'd0);
      check("midrst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      check("midrst_rdata", inst_rdata, 32'd0);
      check("midrst_araddr", axi.araddr, 32'd0);
      check("midrst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      inst_req = 1'b0;
      @(negedge Clk);
      resetn      = 1'b1;
      model_rdata = 32'd0;
      @(negedge Clk);
      run_txn(32'hBFC0_0100, 0, 0, 0, 32'h2408_0001, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_uncache_bridge.md
INST_UNCACHE_BRIDGE -- requirements
Module: inst_uncache_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, ARID value driven on every read.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port inst_req  input  1  fetch stage requests an uncached instruction word.
REQ-005 SHALL have port inst_addr  input  32  request byte address.
REQ-006 SHALL have port exp_flush  input  1  pipeline flush; cancels the request in flight.
REQ-007 SHALL have port inst_addr_ok  output  1  request accepted this cycle.
REQ-008 SHALL have port inst_data_ok  output  1  one-cycle pulse; inst_rdata valid.
REQ-009 SHALL have port inst_rdata  output  32  returned instruction word.
REQ-010 SHALL have port inst_bus_err  output  1  error flag qualified by inst_data_ok.
REQ-011 SHALL have AXI read-channel ports: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid, arready (in), rid[3:0] (in), rdata[31:0] (in), rresp[1:0] (in), rlast (in), rvalid (in), rready.

Function
REQ-012 SHALL use states IDLE, ADDR, DATA and DRAIN, with at most one read outstanding.
REQ-013 SHALL drive arlen=0, arsize=3'b010, arburst=2'b01, araddr={addr[31:2],2'b00}, and ignore rid.
REQ-014 IDLE: inst_addr_ok = inst_req & !exp_flush; on acceptance SHALL latch the address and enter ADDR, with arvalid high from the next cycle.
REQ-015 ADDR: arvalid and araddr SHALL be held stable until arready; on handshake go to DATA, or to DRAIN if a cancel is pending.
REQ-016 exp_flush in ADDR SHALL set a cancel flag; arvalid is never retracted.
REQ-017 DATA/DRAIN: rready SHALL be 1; the state is left only on rvalid & rready & rlast.
REQ-018 DATA handshake without exp_flush in the same cycle SHALL register rdata into inst_rdata, pulse inst_data_ok for exactly one cycle on the next cycle, and return to IDLE.
REQ-019 exp_flush in DATA before the handshake SHALL move to DRAIN; exp_flush in the handshake cycle SHALL suppress inst_data_ok and return to IDLE.
REQ-020 DRAIN SHALL consume the response without asserting inst_data_ok, then return to IDLE.
REQ-021 inst_addr_ok SHALL never be asserted outside IDLE; a new request MAY be accepted in the same cycle as the inst_data_ok pulse.
REQ-022 Minimum latency, with arready and rvalid asserted immediately: accept at cycle N, arvalid at N+1, R handshake at N+2, inst_data_ok at N+3.
REQ-023 inst_rdata SHALL hold its value until the next successful read.

Reset
REQ-024 resetn low SHALL immediately force IDLE, clear the cancel flag, and drive arvalid=0, rready=0, inst_addr_ok=0, inst_data_ok=0, inst_bus_err=0, inst_rdata=0, araddr=0.
REQ-025 Reset mid-transaction SHALL abandon the read without drain; the interconnect is reset by the same signal.

Configuration
REQ-026 With macro INST_UNCACHE_BUS_ERR_EN defined, inst_bus_err SHALL equal (rresp!=2'b00) of the completing beat, pulsed with inst_data_ok.
REQ-027 Without INST_UNCACHE_BUS_ERR_EN, inst_bus_err SHALL be tied 0 and rresp ignored.

Structure
REQ-028 The state enum and the AXI constants (ARSIZE_WORD, ARBURST_INCR, RESP_OKAY) SHALL live in the shared CPU package.
REQ-029 The block SHALL be a single module with no sub-modules.

Verification
REQ-030 Basic read: req addr 0xBFC00004, arready=1, rdata=0x3C08BFC0 one cycle later -> araddr 0xBFC00004; inst_data_ok one cycle with inst_rdata 0x3C08BFC0 at N+3.
REQ-031 AR backpressure: arready low for 5 cycles -> arvalid and araddr stable throughout; a single inst_data_ok follows.
REQ-032 Flush in ADDR: exp_flush 1 cycle after accept, arready after 3 cycles, rvalid later -> no inst_data_ok; next req accepted only after rlast.
REQ-033 Flush in the handshake cycle -> inst_data_ok stays 0; IDLE on the next cycle.
REQ-034 With INST_UNCACHE_BUS_ERR_EN: rresp=2'b10 -> inst_data_ok=1 and inst_bus_err=1; without the macro, inst_bus_err=0.
REQ-035 resetn asserted in DATA -> arvalid, rready and inst_data_ok are 0 immediately; the next req after release is accepted.
